uart_tx_ctrl: RTL and testbench

//  Complete parametrised UART transmit engine: control FSM, shift-register serializer,

---
 rtl/uart_tx_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter (FSM, serializer, parity, registered TX line); define UART_TX_HOLD_EN for a one-entry holding register
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pen_q, pen_d, par_q, par_d, tx_q, tx_d, busy_q, busy_d;
  logic idle, last_stop, accept, load;
  logic [DATA_WIDTH-1:0] src_data;
  logic src_pen, src_typ;
  assign idle      = state_q == IDLE;
  assign last_stop = (state_q == STOP) && (cnt_q == CW'(STOP_BITS - 1));
  assign accept    = data_valid & data_ready;
  assign tx_out    = tx_q;
  assign busy      = busy_q;
`ifdef UART_TX_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic hold_pen_q, hold_typ_q, hold_full_q, hold_go, fill;
  assign data_ready = !hold_full_q;
  assign hold_go    = hold_full_q & (idle | last_stop);
  assign fill       = accept & !idle;
  assign load       = hold_go | (accept & idle);
  assign src_data   = hold_go ? hold_data_q : p_data;
  assign src_pen    = hold_go ? hold_pen_q : par_en;
  assign src_typ    = hold_go ? hold_typ_q : par_typ;
  // Holding register: filled by an accept during a frame, emptied when its frame starts
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_pen_q  <= 1'b0;
      hold_typ_q  <= 1'b0;
    end else begin
      if (fill) begin
        hold_data_q <= p_data;
        hold_pen_q  <= par_en;
        hold_typ_q  <= par_typ;
      end
      hold_full_q <= fill | (hold_full_q & !hold_go);
    end
`else
  assign data_ready = idle;
  assign load       = accept;
  assign src_data   = p_data;
  assign src_pen    = par_en;
  assign src_typ    = par_typ;
`endif
  // Next-state: frame sequencing, serializer shift and per-frame latching of data/parity
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pen_d   = pen_q;
    par_d   = par_q;
    case (state_q)
      IDLE: state_d = IDLE;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = pen_q ? PARITY : STOP;
          cnt_d   = '0;
        end
      end
      PARITY: begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (last_stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      shift_d = src_data;
      pen_d   = src_pen;
      par_d   = ^src_data ^ src_typ;
      cnt_d   = '0;
    end
  end
  // Line level follows the upcoming state so tx_out changes on the same edge as the state
  assign tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  assign busy_d = state_d != IDLE;
  // State and datapath registers; reset abandons any frame and idles the line high
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl (8N1 instance plus a 7-bit, 2-stop instance)
module tb_uart_tx_ctrl;
  logic clk = 1'b0, rstn = 1'b1;
  logic [7:0] pdata = '0;
  logic valid = 1'b0, pen = 1'b0, typ = 1'b0;
  logic ready, tx, busy;
  logic [6:0] d7 = '0;
  logic v7 = 1'b0, pen7 = 1'b0, typ7 = 1'b0;
  logic ready7, tx7, busy7;
  int n_chk = 0, n_fail = 0;
  logic q[$];
  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       typ;
    logic       par;
  } vec_t;
  vec_t tbl[8];

  uart_tx_ctrl dut (
    .clk(clk), .rstn(rstn), .p_data(pdata), .data_valid(valid), .data_ready(ready),
    .par_en(pen), .par_typ(typ), .tx_out(tx), .busy(busy)
  );
  uart_tx_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) dut7 (
    .clk(clk), .rstn(rstn), .p_data(d7), .data_valid(v7), .data_ready(ready7),
    .par_en(pen7), .par_typ(typ7), .tx_out(tx7), .busy(busy7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_tx"}, tx, 1'b1);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  // Scoreboard: expected line levels of one 8-bit, 1-stop frame
  task automatic push_frame(input logic [7:0] d, input logic p_en, input logic par);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (p_en) q.push_back(par);
    q.push_back(1'b1);
  endtask

  // Pop one expected bit per cycle; optionally raise/drop data_valid at given bit indices
  task automatic drain(input bit sel, input int set_at, input int drop_at);
    int i = 0;
    logic e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (set_at >= 0 && i == set_at) begin
        chk("ready_midframe", ready, 1'b0);
        valid = 1'b1;
        pdata = 8'h33;
      end
      if (drop_at >= 0 && i == drop_at) valid = 1'b0;
      chk("tx_bit", sel ? tx7 : tx, e);
      chk("busy_frame", sel ? busy7 : busy, 1'b1);
      @(negedge clk);
      i++;
    end
  endtask

  // Offer one frame, then scramble inputs so the frame in flight must use latched values
  task automatic send(input logic [7:0] d, input logic p_en, input logic p_typ, input logic par);
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", ready, 1'b1);
    pdata = d;
    pen   = p_en;
    typ   = p_typ;
    valid = 1'b1;
    push_frame(d, p_en, par);
    @(negedge clk);
    valid = 1'b0;
    pdata = ~d;
    pen   = ~p_en;
    typ   = ~p_typ;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] seq7;
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h0F, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b0};
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_ready", ready, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("release");
    chk("release_ready", ready, 1'b1);
    // Table-driven frames on the 8-bit instance
    foreach (tbl[k]) begin
      send(tbl[k].d, tbl[k].pen, tbl[k].typ, tbl[k].par);
      drain(0, -1, -1);
      chk_idle("after_frame");
    end
    // 7-bit, 2-stop, odd parity: 0, 1000001, 1, 1, 1
    seq7 = 11'b01000001111;
    d7   = 7'h41;
    pen7 = 1'b1;
    typ7 = 1'b1;
    v7   = 1'b1;
    for (int i = 10; i >= 0; i--) q.push_back(seq7[i]);
    @(negedge clk);
    v7 = 1'b0;
    d7 = 7'h3E;
    drain(1, -1, -1);
    chk("w7_idle_tx", tx7, 1'b1);
    chk("w7_idle_busy", busy7, 1'b0);
    // data_valid held high across back-to-back frames
    pdata = 8'h55;
    pen   = 1'b0;
    valid = 1'b1;
`ifdef UART_TX_HOLD_EN
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    drain(0, -1, 10);
    chk_idle("b2b_hold_end");
`else
    push_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    drain(0, -1, -1);
    chk_idle("b2b_gap");
    chk("b2b_gap_ready", ready, 1'b1);
    @(negedge clk);
    push_frame(8'h55, 1'b0, 1'b0);
    drain(0, -1, 0);
    chk_idle("b2b_end");
`endif
    // Asynchronous reset during data bit 3, then a clean frame
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("pre_reset_bit", tx, q.pop_front());
      @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_ready", ready, 1'b1);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    drain(0, -1, -1);
    chk_idle("post_reset_frame");
`ifndef UART_TX_HOLD_EN
    // data_valid pulse while not ready must be ignored
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    drain(0, 3, 4);
    for (int i = 0; i < 3; i++) begin
      chk_idle("ignored_pulse");
      @(negedge clk);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
